classifier_frame_sequencer: RTL and testbench

Sequential front end for the combinational printed ML classifiers (cardio SVM and successors). Accepts input features one per cycle over a valid/ready stream, assembles them into the flat `inp` vector driven into the classifier core, waits a programmable settle interval, then captures the classifier decision and presents it on a valid/ready output stream. It is parametrised in feature width, feature count, output width and settle latency, so one block serves every classifier in the suite.

---
 rtl/classifier_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_classifier_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/classifier_frame_sequencer.sv
// classifier_frame_sequencer: streams features into a flat classifier input
// vector, waits a fixed settle interval, then captures and hands off the
// classifier decision over a valid/ready output stream.
module classifier_frame_sequencer #(
    parameter int unsigned WIDTH_A  = 4,
    parameter int unsigned NUM_A    = 21,
    parameter int unsigned OUTWIDTH = 14,
    parameter int unsigned SETTLE   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH_A-1:0]        in_data,
    input  logic                      in_last,
    output logic [NUM_A*WIDTH_A-1:0]  inp,
    input  logic [OUTWIDTH-1:0]       cls_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUTWIDTH-1:0]       out_data,
    output logic                      frame_err,
    output logic [15:0]               frame_cnt
);

    localparam int unsigned IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_A - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic idx_at_last;
    logic short_frame;
    logic long_frame;
    logic result_hs;

    assign accept      = in_valid & in_ready;
    assign idx_at_last = (idx == IDX_LAST);
    assign short_frame = accept & in_last & ~idx_at_last;
    assign long_frame  = accept & idx_at_last & ~in_last;
    assign result_hs   = out_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (accept && idx_at_last) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (result_hs) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Output decode: input side is open only while loading
    always_comb begin
        in_ready = 1'b0;
        if (state == ST_LOAD) begin
            in_ready = 1'b1;
        end
    end

    // Datapath: feature slots, settle counter, result capture, frame counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            inp       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= short_frame | long_frame;
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        for (int g = 0; g < int'(NUM_A); g++) begin
                            if (idx == IDX_W'(g)) begin
                                inp[g*WIDTH_A +: WIDTH_A] <= in_data;
                            end
                        end
                        if (idx_at_last) begin
                            idx <= '0;
                            cnt <= CNT_INIT;
                        end else if (in_last) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        out_data  <= cls_out;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (result_hs) begin
                        out_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_classifier_frame_sequencer.sv
// Directed bench for classifier_frame_sequencer with default parameters.
module tb_classifier_frame_sequencer;

    localparam int unsigned WIDTH_A  = 4;
    localparam int unsigned NUM_A    = 21;
    localparam int unsigned OUTWIDTH = 14;
    localparam int unsigned SETTLE   = 4;
    localparam int unsigned VEC_W    = NUM_A * WIDTH_A;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH_A-1:0]  in_data;
    logic                in_last;
    logic [VEC_W-1:0]    inp;
    logic [OUTWIDTH-1:0] cls_out;
    logic                out_valid;
    logic                out_ready;
    logic [OUTWIDTH-1:0] out_data;
    logic                frame_err;
    logic [15:0]         frame_cnt;

    int n_checks;
    int n_fail;

    classifier_frame_sequencer #(
        .WIDTH_A (WIDTH_A),
        .NUM_A   (NUM_A),
        .OUTWIDTH(OUTWIDTH),
        .SETTLE  (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .inp      (inp),
        .cls_out  (cls_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in classifier core: fold the two ends of the vector together
    assign cls_out = inp[13:0] ^ inp[VEC_W-1 -: 14];

    function automatic logic [OUTWIDTH-1:0] model_cls(input logic [VEC_W-1:0] v);
        return v[13:0] ^ v[VEC_W-1 -: 14];
    endfunction

    function automatic logic [WIDTH_A-1:0] feat(input int pat, input int g);
        case (pat)
            0:       return WIDTH_A'(g % 16);
            1:       return WIDTH_A'((3 * g + 1) % 16);
            default: return WIDTH_A'(15 - (g % 16));
        endcase
    endfunction

    function automatic logic [VEC_W-1:0] vec_of(input int pat);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int g = 0; g < int'(NUM_A); g++) begin
            v[g*WIDTH_A +: WIDTH_A] = feat(pat, g);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one feature (optionally after idle gap cycles); returns just after the accept edge
    task automatic send(input logic [WIDTH_A-1:0] d, input logic last, input int gap,
                        input logic exp_err);
        int guard;
        guard = 0;
        for (int k = 0; k < gap; k++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("frame_err", 128'(frame_err), 128'(exp_err));
    endtask

    // Stream a whole frame; last_flag is the in_last value of the final feature
    task automatic send_frame(input int pat, input logic last_flag, input logic rnd_gaps);
        for (int g = 0; g < int'(NUM_A); g++) begin
            logic is_last;
            is_last = (g == int'(NUM_A) - 1);
            send(feat(pat, g), is_last ? last_flag : 1'b0,
                 rnd_gaps ? int'($urandom_range(0, 2)) : 0,
                 is_last & ~last_flag);
        end
    endtask

    // Count edges after the last accept until out_valid appears
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                check("settle_in_ready", 128'(in_ready), 128'd0);
                check("err_one_cycle", 128'(frame_err), 128'd0);
            end
            if (out_valid) break;
        end
    endtask

    // Full frame with out_ready high: checks vector, latency, result, handshake
    task automatic run_frame(input int pat, input logic last_flag, input logic rnd_gaps,
                             input logic [15:0] exp_cnt);
        int lat;
        send_frame(pat, last_flag, rnd_gaps);
        check("inp_vector", 128'(inp), 128'(vec_of(pat)));
        wait_result(lat);
        check("latency", 128'(lat), 128'(SETTLE));
        check("out_data", 128'(out_data), 128'(model_cls(vec_of(pat))));
        @(posedge clk);
        #1;
        check("hs_out_valid", 128'(out_valid), 128'd0);
        check("hs_in_ready", 128'(in_ready), 128'd1);
        check("frame_cnt", 128'(frame_cnt), 128'(exp_cnt));
    endtask

    initial begin
        int lat;
        logic [OUTWIDTH-1:0] held;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_inp", 128'(inp), 128'd0);
        check("rst_frame_cnt", 128'(frame_cnt), 128'd0);
        check("rst_out_data", 128'(out_data), 128'd0);
        check("rst_frame_err", 128'(frame_err), 128'd0);

        // Nominal frame; result is hand-computed for the g mod 16 ramp
        run_frame(0, 1'b1, 1'b0, 16'd1);
        check("nominal_const", 128'(out_data), 128'h22D8);

        // Back-pressure
        out_ready = 1'b0;
        send_frame(1, 1'b1, 1'b0);
        wait_result(lat);
        check("bp_latency", 128'(lat), 128'(SETTLE));
        held = out_data;
        check("bp_out_data", 128'(held), 128'(model_cls(vec_of(1))));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_last  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_data", 128'(out_data), 128'(held));
            check("bp_hold_valid", 128'(out_valid), 128'd1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        check("bp_inp_untouched", 128'(inp), 128'(vec_of(1)));
        check("bp_cnt_held", 128'(frame_cnt), 128'd1);
        check("bp_no_err", 128'(frame_err), 128'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_valid", 128'(out_valid), 128'd0);
        check("bp_hs_cnt", 128'(frame_cnt), 128'd2);
        check("bp_hs_in_ready", 128'(in_ready), 128'd1);

        // Short frame: in_last on the 5th feature
        for (int g = 0; g < 5; g++) begin
            send(feat(2, g), (g == 4), 0, (g == 4));
        end
        @(posedge clk);
        #1;
        check("short_err_clear", 128'(frame_err), 128'd0);
        repeat (6) @(posedge clk);
        #1;
        check("short_no_result", 128'(out_valid), 128'd0);
        check("short_cnt", 128'(frame_cnt), 128'd2);
        check("short_in_ready", 128'(in_ready), 128'd1);
        run_frame(2, 1'b1, 1'b0, 16'd3);

        // Long frame: final feature without in_last
        run_frame(1, 1'b0, 1'b0, 16'd4);

        // Reset during SETTLE
        send_frame(0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_inp", 128'(inp), 128'd0);
        check("mid_rst_out_data", 128'(out_data), 128'd0);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_cnt", 128'(frame_cnt), 128'd0);
        check("mid_rst_err", 128'(frame_err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_no_result", 128'(out_valid), 128'd0);

        // Frame with random in_valid gaps matches the gap-free nominal result
        run_frame(0, 1'b1, 1'b1, 16'd1);
        check("gap_const", 128'(out_data), 128'h22D8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
